// File: rtl/ring_shift_sequencer.sv
// rtl/ring_shift_sequencer.sv - ring register preset by serial load, then rotated a counted number of steps
module ring_shift_sequencer #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] rot_count,
    output logic [WIDTH-1:0] number,
    output logic             ser_load,
    output logic             ser_data,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_ROTATE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_pat;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_number;
    logic             w_ser_bit;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_next = abort ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_idx == '0) begin
                    w_next = (r_cnt != '0) ? S_ROTATE : S_DONE;
                end
            end
            S_ROTATE: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign w_ser_bit = r_pat[r_idx];
    assign ser_load  = (r_state == S_LOAD);
    assign ser_data  = ser_load & w_ser_bit;
    assign busy      = (r_state == S_CLEAR) || (r_state == S_LOAD) || (r_state == S_ROTATE);
    assign done      = (r_state == S_DONE);
    assign number    = r_number;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_number <= '0;
            r_pat    <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pat <= pattern;
                        r_cnt <= rot_count;
                    end
                end
                S_CLEAR: begin
                    if (!abort) begin
                        r_number <= '0;
                        r_idx    <= IDX_TOP;
                    end
                end
                S_LOAD: begin
                    if (!abort) begin
                        r_number <= {r_number[WIDTH-2:0], w_ser_bit};
                        if (r_idx != '0) r_idx <= r_idx - IDX_W'(1);
                    end
                end
                S_ROTATE: begin
                    if (!abort) begin
                        r_number <= {r_number[WIDTH-2:0], r_number[WIDTH-1]};
                        r_cnt    <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_shift_sequencer.sv
// tb/tb_ring_shift_sequencer.sv - scoreboard bench for ring_shift_sequencer
module tb_ring_shift_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       abort;
    logic [5:0] pattern;
    logic [7:0] rot_count;
    logic [5:0] number;
    logic       ser_load;
    logic       ser_data;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    logic       exp_ser[$];
    logic [5:0] exp_num[$];

    ring_shift_sequencer #(.WIDTH(6), .CNT_W(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .abort     (abort),
        .pattern   (pattern),
        .rot_count (rot_count),
        .number    (number),
        .ser_load  (ser_load),
        .ser_data  (ser_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] rotl(input logic [5:0] p, input int k);
        logic [5:0] r;
        r = p;
        for (int i = 0; i < k; i++) r = {r[4:0], r[5]};
        return r;
    endfunction

    // Monitor: serial strobe and done pulse each consume one scoreboard entry.
    always @(negedge clk) begin
        if (ser_load) begin
            if (exp_ser.size() == 0) begin
                check("unexpected_ser_load", 32'(ser_load), 32'd0);
            end else begin
                check("ser_data", 32'(ser_data), 32'(exp_ser.pop_front()));
            end
        end
        if (done) begin
            if (exp_num.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                check("final_number", 32'(number), 32'(exp_num.pop_front()));
            end
        end
    end

    task automatic push_ser(input logic [5:0] pat);
        for (int i = 5; i >= 0; i--) exp_ser.push_back(pat[i]);
    endtask

    task automatic do_run(input logic [5:0] pat, input logic [7:0] n,
                          input bit hold_start, input logic [5:0] alt_pat);
        int  cycles;
        bit  seen;
        push_ser(pat);
        exp_num.push_back(rotl(pat, int'(n) % 6));
        @(negedge clk);
        start     = 1'b1;
        pattern   = pat;
        rot_count = n;
        cycles    = 0;
        seen      = 1'b0;
        while (!seen && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                if (hold_start) begin
                    pattern   = alt_pat;
                    rot_count = 8'd1;
                end else begin
                    start = 1'b0;
                end
            end
            if (cycles >= 8 && cycles < 8 + int'(n))
                check("rotate_step", 32'(number), 32'(rotl(pat, cycles - 8)));
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_latency", 32'(cycles), 32'(8 + int'(n)));
            check("busy_in_done", 32'(busy), 32'd0);
        end
        @(negedge clk);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
        check("number_hold", 32'(number), 32'(rotl(pat, int'(n) % 6)));
    endtask

    initial begin
        clr       = 1'b1;
        start     = 1'b1;
        abort     = 1'b1;
        pattern   = 6'h2a;
        rot_count = 8'd7;
        repeat (3) @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        check("reset_number", 32'(number), 32'd0);
        check("reset_flags", {28'd0, busy, done, ser_load, ser_data}, 32'd0);

        do_run(6'b101100, 8'd0,   1'b0, 6'd0);
        do_run(6'b000001, 8'd3,   1'b0, 6'd0);
        do_run(6'b000001, 8'd6,   1'b0, 6'd0);
        do_run(6'b000001, 8'd255, 1'b0, 6'd0);

        // Abort on the third ROTATE edge: number keeps the value from the second step.
        push_ser(6'b000001);
        @(negedge clk);
        start     = 1'b1;
        pattern   = 6'b000001;
        rot_count = 8'd5;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_number", 32'(number), 32'(6'b000100));
        check("abort_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end

        do_run(6'b110010, 8'd2, 1'b1, 6'b011111);

        // Reset during the third LOAD cycle.
        push_ser(6'b111111);
        @(negedge clk);
        start     = 1'b1;
        pattern   = 6'b111111;
        rot_count = 8'd4;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        exp_ser.delete();
        check("midrun_clr_number", 32'(number), 32'd0);
        check("midrun_clr_flags", {29'd0, busy, done, ser_load}, 32'd0);
        repeat (3) @(negedge clk);
        check("midrun_clr_no_done", 32'(done), 32'd0);

        do_run(6'b100000, 8'd1, 1'b0, 6'd0);

        check("ser_queue_drained", 32'(exp_ser.size()), 32'd0);
        check("num_queue_drained", 32'(exp_num.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
